// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation encodings, FSM states, default latencies and small helpers.
package md_pkg;

  // Operation codes presented by the decoder on md_op (0 = no MD operation).
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // Sequencer states: IDLE accepts commands, RUN counts down the latency.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Latency counter width; comfortably covers any realistic cycle count.
  localparam int MD_CNT_W = 8;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Decoder/hazard-unit side bundle of the multiply/divide sequencer.
// master = command source (decoder / testbench), slave = md_sequencer.
interface md_sequencer_if;
  import md_pkg::*;

  logic        start;
  logic        md_write;
  md_op_e      md_op;
  logic        md_sel;
  logic        req;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;

  modport master (
    output start, md_write, md_op, md_sel, req, rs_val, rt_val,
    input  busy, stall_md, md_out
  );

  modport slave (
    input  start, md_write, md_op, md_sel, req, rs_val, rt_val,
    output busy, stall_md, md_out
  );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit multiply / divide datapath.
// Produces {hi, lo} = product, or {remainder, quotient} for divides,
// plus a flag marking a divide by zero (result must not be committed).
module md_arith
  import md_pkg::*;
(
  input  md_op_e      i_md_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_rt_zero;
  logic               w_div_ovf;
  logic        [31:0] w_sdivisor;
  logic        [31:0] w_udivisor;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;

  assign w_prod_s = $signed({{32{i_rs_val[31]}}, i_rs_val}) *
                    $signed({{32{i_rt_val[31]}}, i_rt_val});
  assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

  // Divisor zero would give X; the most-negative / -1 case overflows.
  // Dividing by 1 instead yields quotient = dividend, remainder = 0,
  // which is exactly the required 0x80000000 / -1 answer.
  assign w_rt_zero  = (i_rt_val == 32'd0);
  assign w_div_ovf  = (i_rs_val == 32'h8000_0000) && (i_rt_val == 32'hFFFF_FFFF);
  assign w_sdivisor = (w_rt_zero || w_div_ovf) ? 32'd1 : i_rt_val;
  assign w_udivisor = w_rt_zero ? 32'd1 : i_rt_val;

  // Verilog signed % already gives the remainder the sign of the dividend.
  assign w_quo_s = $signed(i_rs_val) / $signed(w_sdivisor);
  assign w_rem_s = $signed(i_rs_val) % $signed(w_sdivisor);
  assign w_quo_u = i_rs_val / w_udivisor;
  assign w_rem_u = i_rs_val % w_udivisor;

  assign o_div_zero = md_is_div(i_md_op) && w_rt_zero;

  // Select the result pair for the requested operation.
  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    case (i_md_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV: begin
        o_hi = w_rem_s;
        o_lo = w_quo_s;
      end
      MD_DIVU: begin
        o_hi = w_rem_u;
        o_lo = w_quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage.
// Latches the arithmetic result on start, holds busy for the operation
// latency, then commits HI/LO. MTHI/MTLO write in a single cycle.
// Optional macro MDU_FAST_EN: results commit on the edge after start,
// busy and stall_md stay 0 and the cycle parameters are unused.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  md_sequencer_if.slave bus
);

  md_state_e             r_state, w_state_next;
  logic [MD_CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [31:0]           r_hi, w_hi_next;
  logic [31:0]           r_lo, w_lo_next;
  logic [31:0]           r_hi_nxt, w_hi_stage;
  logic [31:0]           r_lo_nxt, w_lo_stage;
  logic                  r_dz, w_dz_next;

  logic [31:0]           w_ar_hi;
  logic [31:0]           w_ar_lo;
  logic                  w_div_zero;
  logic                  w_accept;
  logic                  w_mt;

  md_arith u_arith (
    .i_md_op    (bus.md_op),
    .i_rs_val   (bus.rs_val),
    .i_rt_val   (bus.rt_val),
    .o_hi       (w_ar_hi),
    .o_lo       (w_ar_lo),
    .o_div_zero (w_div_zero)
  );

  // A req in the same cycle cancels any command presented in E.
  assign w_accept = bus.start & ~bus.req;
  assign w_mt     = bus.md_write & ~bus.start & ~bus.req;

  // Next-state and register-update decisions; everything holds by default.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_hi_stage   = r_hi_nxt;
    w_lo_stage   = r_lo_nxt;
    w_dz_next    = r_dz;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef MDU_FAST_EN
          if (!w_div_zero) begin
            w_hi_next = w_ar_hi;
            w_lo_next = w_ar_lo;
          end
`else
          w_hi_stage   = w_ar_hi;
          w_lo_stage   = w_ar_lo;
          w_dz_next    = w_div_zero;
          w_cnt_next   = md_is_div(bus.md_op) ? MD_CNT_W'(DIV_CYCLES)
                                              : MD_CNT_W'(MULT_CYCLES);
          w_state_next = ST_RUN;
`endif
        end else if (w_mt) begin
          if (bus.md_op == MD_MTHI) begin
            w_hi_next = bus.rs_val;
          end else if (bus.md_op == MD_MTLO) begin
            w_lo_next = bus.rs_val;
          end
        end
      end
      ST_RUN: begin
        // Commands and req are ignored here: the op is already issued.
        w_cnt_next = r_cnt - MD_CNT_W'(1);
        if (r_cnt == MD_CNT_W'(1)) begin
          w_state_next = ST_IDLE;
          if (!r_dz) begin
            w_hi_next = r_hi_nxt;
            w_lo_next = r_lo_nxt;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counter, staged result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_nxt <= 32'd0;
      r_lo_nxt <= 32'd0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_hi_nxt <= w_hi_stage;
      r_lo_nxt <= w_lo_stage;
      r_dz     <= w_dz_next;
    end
  end

`ifdef MDU_FAST_EN
  assign bus.busy     = 1'b0;
  assign bus.stall_md = 1'b0;
`else
  assign bus.busy     = (r_state == ST_RUN);
  // Stall already in the start cycle so a following MFHI/MFLO waits.
  assign bus.stall_md = (r_state == ST_RUN) | (bus.start & ~bus.req);
`endif

  // Only committed HI/LO are ever visible; the staged result stays hidden.
  assign bus.md_out = bus.md_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed testbench for md_sequencer: a vector table of MD operations
// plus hand-written sequences for req, reset and back-to-back corners.
module tb_md_sequencer;
  import md_pkg::*;

`ifdef MDU_FAST_EN
  localparam int MC = 0;
  localparam int DC = 0;
`else
  localparam int MC = 5;
  localparam int DC = 10;
`endif
  localparam bit STALL_START = (MC != 0);

  typedef struct {
    md_op_e      op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_cmd_err = 0;
  vec_t vecs [9];

  md_sequencer_if bus ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Commands must never arrive while an operation is in flight.
  always @(posedge clk) begin
    if (reset_n && bus.busy && (bus.start || bus.md_write)) n_cmd_err++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive_idle();
    bus.start    = 1'b0;
    bus.md_write = 1'b0;
    bus.md_op    = MD_NONE;
    bus.md_sel   = 1'b0;
    bus.req      = 1'b0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.md_sel = 1'b1;
    #1 hi = bus.md_out;
    bus.md_sel = 1'b0;
    #1 lo = bus.md_out;
  endtask

  // One-cycle MTHI/MTLO, optionally cancelled by req.
  task automatic mt(input md_op_e op, input logic [31:0] val, input logic rq);
    bus.md_write = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = val;
    bus.req      = rq;
    @(negedge clk);
    drive_idle();
  endtask

  // Issue one MULT/DIV, count busy cycles and check the committed result.
  task automatic run_op(input string nm, input md_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pre_hi,
                        input logic [31:0] pre_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc);
    logic [31:0] hi, lo;
    int cnt;
    bus.start    = 1'b1;
    bus.md_write = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    #1 check({nm, " stall"}, 32'(bus.stall_md), 32'(STALL_START));
    @(negedge clk);
    drive_idle();
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      if (cnt == 1) begin
        read_hilo(hi, lo);
        check({nm, " hold_hi"}, hi, pre_hi);
        check({nm, " hold_lo"}, lo, pre_lo);
      end
      cnt++;
      @(negedge clk);
    end
    if (bus.busy) begin
      n_total++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, expected 0", nm, cnt);
    end
    check({nm, " cycles"}, 32'(cnt), 32'(exp_cyc));
    read_hilo(hi, lo);
    check({nm, " hi"}, hi, exp_hi);
    check({nm, " lo"}, lo, exp_lo);
    $display("%s: op=%0d rs=0x%08h rt=0x%08h busy=%0d hi=0x%08h lo=0x%08h",
             nm, op, rs, rt, cnt, hi, lo);
  endtask

  initial begin
    logic [31:0] hi, lo;
    int cnt;
    bit seen_busy;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA, MC};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[3] = '{MD_DIVU,  32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DC};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h0, 32'h8000_0000, DC};
    vecs[5] = '{MD_DIVU,  32'd100, 32'd7, 32'h3, 32'h4, 32'd2, 32'd14, DC};
    vecs[6] = '{MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'h5, 32'h6, 32'd1, 32'hFFFF_FFFD, DC};
    vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h7, 32'h8, 32'h4000_0000, 32'h0, MC};
    vecs[8] = '{MD_DIV,   32'd5, 32'd0, 32'hAA, 32'hBB, 32'hAA, 32'hBB, DC};

    drive_idle();
    reset_n = 1'b0;
    #2;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset stall", 32'(bus.stall_md), 32'd0);
    read_hilo(hi, lo);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // MTLO visible on md_out in the following cycle.
    mt(MD_MTLO, 32'h0000_1234, 1'b0);
    #1 check("mtlo lo", bus.md_out, 32'h0000_1234);
    $display("mtlo: lo=0x%08h", bus.md_out);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mt(MD_MTHI, vecs[i].pre_hi, 1'b0);
      mt(MD_MTLO, vecs[i].pre_lo, 1'b0);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].pre_hi, vecs[i].pre_lo, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc);
    end

    // Back-to-back: second DIV issued in the first idle cycle.
    mt(MD_MTHI, 32'h0, 1'b0);
    mt(MD_MTLO, 32'h0, 1'b0);
    run_op("b2b_1", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    run_op("b2b_2", MD_DIV, 32'd9, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd2, DC);

    // MULT with req in the same cycle is dropped completely.
    mt(MD_MTHI, 32'h55, 1'b0);
    mt(MD_MTLO, 32'h66, 1'b0);
    bus.start = 1'b1; bus.md_write = 1'b1; bus.md_op = MD_MULT;
    bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.req = 1'b1;
    #1 check("req_cancel stall", 32'(bus.stall_md), 32'd0);
    @(negedge clk);
    drive_idle();
    seen_busy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy) seen_busy = 1'b1;
      @(negedge clk);
    end
    check("req_cancel busy", 32'(seen_busy), 32'd0);
    read_hilo(hi, lo);
    check("req_cancel hi", hi, 32'h55);
    check("req_cancel lo", lo, 32'h66);
    $display("req_cancel: busy_seen=%0d hi=0x%08h lo=0x%08h", seen_busy, hi, lo);

    // MTHI with req is dropped as well.
    mt(MD_MTHI, 32'hDEAD, 1'b1);
    read_hilo(hi, lo);
    check("req_mthi hi", hi, 32'h55);
    $display("req_mthi: hi=0x%08h", hi);
    @(negedge clk);

    // req during RUN does not cancel the issued MULT.
    bus.start = 1'b1; bus.md_write = 1'b1; bus.md_op = MD_MULT;
    bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(negedge clk);
    drive_idle();
    bus.req = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    bus.req = 1'b0;
    check("req_run cycles", 32'(cnt), 32'(MC));
    read_hilo(hi, lo);
    check("req_run hi", hi, 32'd0);
    check("req_run lo", lo, 32'd12);
    $display("req_run: busy=%0d hi=0x%08h lo=0x%08h", cnt, hi, lo);
    @(negedge clk);

    // Reset mid-RUN discards the op and clears HI/LO immediately.
    mt(MD_MTHI, 32'h77, 1'b0);
    mt(MD_MTLO, 32'h88, 1'b0);
    bus.start = 1'b1; bus.md_write = 1'b1; bus.md_op = MD_DIVU;
    bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("rst_run busy_before", 32'(bus.busy), 32'(DC > 2));
    reset_n = 1'b0;
    #1 check("rst_run busy", 32'(bus.busy), 32'd0);
    read_hilo(hi, lo);
    check("rst_run hi", hi, 32'd0);
    check("rst_run lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) @(negedge clk);
    check("rst_run busy_after", 32'(bus.busy), 32'd0);
    read_hilo(hi, lo);
    check("rst_run hi_after", hi, 32'd0);
    check("rst_run lo_after", lo, 32'd0);
    $display("rst_run: hi=0x%08h lo=0x%08h", hi, lo);

    check("cmd_in_run count", 32'(n_cmd_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource in the E stage.
- Accepts the decoder's Start / MDOp / MDWrite controls and computes the product or quotient/remainder.
- Holds the result for a fixed latency while raising Busy, then commits HI/LO.
- Gives the hazard unit one signal to stall D-stage HI/LO users; honours exception-cancel from the M stage.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU.
- md_write  input  1  E-stage instruction writes HI/LO (includes MTHI/MTLO).
- md_op  input  3  operation code (md_pkg).
- md_sel  input  1  read select: 1 = HI, 0 = LO.
- req  input  1  exception/interrupt taken this cycle; cancels the E-stage request.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  operation in flight.
- stall_md  output  1  busy | (start & ~req); drives the D-stage stall for MD-class instructions.
- md_out  output  32  HI or LO per md_sel; feeds the RS_MD writeback mux.

## Operation
- States:
  - IDLE: accepts commands.
  - RUN: counter active, result staged in internal hi_nxt/lo_nxt.
- IDLE, start & ~req:
  - Latch the result: MULT signed 64-bit, MULTU unsigned 64-bit, DIV signed {rem,quo}, DIVU unsigned {rem,quo}.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE, md_write & ~start & ~req: MTHI/MTLO writes rs_val into HI/LO at the next edge. No busy.
- RUN: the counter decrements each cycle. On the cycle the counter reaches 1, the next edge commits hi_nxt/lo_nxt to HI/LO and returns to IDLE.
- A req arriving while in RUN does not cancel: the operation was already issued.
- A req in the same cycle as start or md_write suppresses that command entirely. HI/LO and state are unchanged.
- start or md_write while in RUN is ignored, because the hazard unit guarantees none arrive. The bench flags any that do as an error.
- Divide by zero (rt_val == 0, DIV/DIVU): sequence and busy proceed normally. HI/LO are left unchanged at commit.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- Remainder takes the sign of the dividend.
- md_out is combinational from committed HI/LO. It never exposes hi_nxt/lo_nxt.

## Timing
- Reset, asynchronous: state IDLE, counter 0, HI = LO = 0, busy = 0, stall_md = 0, md_out = 0.
- Reset asserted during RUN: the in-flight operation is discarded immediately and HI/LO clear.
- Busy rises the edge after start and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO are updated on the edge where busy falls.
- A new start is accepted in the first cycle busy is low, giving back-to-back throughput of N+1 cycles.
- MTHI/MTLO: 1-cycle write; the value is visible on md_out in the following cycle.
- stall_md is combinational and is high in the start cycle itself. MFHI/MFLO behind a MULT in D therefore stalls with no bubble miscount.

## Configuration
- MDU_FAST_EN defined:
  - start commits the result at the next edge; busy is constant 0.
  - stall_md reduces to 0; parameters are ignored.
  - Divide-by-zero and req rules are unchanged.
- MDU_FAST_EN undefined: multi-cycle behaviour as above. This is the default.

## Structure
- md_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO; value 0 = none.
  - State enum.
  - Default cycle constants.
- One sub-module, md_arith: purely combinational 64-bit mult/div result from md_op, rs_val and rt_val, with the div-by-zero flag. md_sequencer owns the FSM, counter and HI/LO registers.

## Test plan
- MULT 0xFFFFFFFE × 3:
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - busy high for 5 cycles; md_out updates on the falling edge of busy.
- MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 busy cycles. A second DIV in the next idle cycle is accepted.
- DIVU 5 / 0 with HI = 0x11, LO = 0x22 beforehand → after 10 busy cycles, HI/LO are still 0x11/0x22.
- MULT with req high in the same cycle → busy stays 0 and HI/LO are unchanged.
- req during RUN → the result still commits. reset_n low mid-RUN → busy drops at once and HI = LO = 0.
- MTLO 0x1234 → md_sel = 0 reads 0x1234 the next cycle. With MDU_FAST_EN defined, MULT 3 × 4 gives LO = 12 one cycle later and busy never asserts.
